// File: rtl/iir_sample_sequencer.sv
// iir_sample_sequencer: buffers incoming samples and hands them one at a time to the IIR core,
// waiting for each result (or a timeout) before forwarding it downstream on a valid/ready port.
module iir_sample_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_sample,
    input  logic                     in_val,
    output logic [31:0]              filt_audio_in,
    output logic                     filt_data_val,
    input  logic [31:0]              filt_audio_out,
    input  logic                     filt_audio_out_val,
    output logic [31:0]              out_sample,
    output logic                     out_val,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow_err,
    output logic                     timeout_err,
    input  logic                     clear_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   filt_audio_in_q, filt_audio_in_d, out_sample_q, out_sample_d;
    logic          filt_data_val_q, filt_data_val_d, out_val_q, out_val_d;
    logic          ovf_q, ovf_d, tmo_q, tmo_d;
    logic          push, pop, expire;

    always_comb begin
        push            = in_val && count_q != LW'(DEPTH);
        pop             = state_q == S_ISSUE;
        expire          = state_q == S_WAIT && !filt_audio_out_val && cnt_q == CW'(TIMEOUT - 2);
        wr_ptr_d        = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d        = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d         = count_q + LW'(push) - LW'(pop);
        ovf_d           = (ovf_q && !clear_err) || (in_val && !push);
        tmo_d           = (tmo_q && !clear_err) || expire;
        state_d         = state_q;
        cnt_d           = cnt_q;
        filt_audio_in_d = filt_audio_in_q;
        filt_data_val_d = 1'b0;
        out_sample_d    = out_sample_q;
        out_val_d       = out_val_q;
        // The sample word is loaded on entry to ISSUE so it is already stable during the start pulse
        case (state_q)
            S_IDLE: if (count_q != '0 && !out_val_q) begin
                state_d         = S_ISSUE;
                filt_audio_in_d = mem_q[rd_ptr_q];
                filt_data_val_d = 1'b1;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (filt_audio_out_val) begin
                    out_sample_d = filt_audio_out;
                    out_val_d    = 1'b1;
                    state_d      = S_OUT;
                end else if (expire) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: if (out_ready) begin
                out_val_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            cnt_q           <= '0;
            filt_audio_in_q <= '0;
            filt_data_val_q <= 1'b0;
            out_sample_q    <= '0;
            out_val_q       <= 1'b0;
            ovf_q           <= 1'b0;
            tmo_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            cnt_q           <= cnt_d;
            filt_audio_in_q <= filt_audio_in_d;
            filt_data_val_q <= filt_data_val_d;
            out_sample_q    <= out_sample_d;
            out_val_q       <= out_val_d;
            ovf_q           <= ovf_d;
            tmo_q           <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_sample;
    end

    assign filt_audio_in = filt_audio_in_q;
    assign filt_data_val = filt_data_val_q;
    assign out_sample    = out_sample_q;
    assign out_val       = out_val_q;
    assign fifo_level    = count_q;
    assign overflow_err  = ovf_q;
    assign timeout_err   = tmo_q;
endmodule

// File: tb/tb_iir_sample_sequencer.sv
// tb_iir_sample_sequencer: directed and randomized checks against a timestamp/queue reference model.
module tb_iir_sample_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, in_val, filt_data_val, filt_audio_out_val, out_val, out_ready;
    logic        overflow_err, timeout_err, clear_err;
    logic [31:0] in_sample, filt_audio_in, filt_audio_out, out_sample;
    logic [3:0]  fifo_level;

    iir_sample_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_val(in_val),
        .filt_audio_in(filt_audio_in), .filt_data_val(filt_data_val),
        .filt_audio_out(filt_audio_out), .filt_audio_out_val(filt_audio_out_val),
        .out_sample(out_sample), .out_val(out_val), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow_err(overflow_err), .timeout_err(timeout_err),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sample queue plus timestamps for the in-flight sample.
    logic [31:0] mq[$];
    bit          mv = 0;
    int          mc = 0;
    bit          busy;
    int          pulse_at, free_at;
    bit          e_fdv, e_oval, e_ovf, e_tmo;
    logic [31:0] e_fain, e_osamp;
    int          e_lvl;

    always @(posedge clk) begin
        bit full, nonempty, tmo_ev, fire;
        mc++;
        if (rst) begin
            mq.delete();
            busy = 0; free_at = mc + 2; pulse_at = 0;
            e_fdv = 0; e_oval = 0; e_ovf = 0; e_tmo = 0; e_fain = '0; e_osamp = '0; e_lvl = 0;
            mv = 1;
        end else begin
            full     = mq.size() == DEPTH;
            nonempty = mq.size() != 0;
            tmo_ev   = 0;
            if (busy && !e_oval && mc > pulse_at && mc < pulse_at + TIMEOUT) begin
                if (filt_audio_out_val) begin
                    e_oval  = 1;
                    e_osamp = filt_audio_out;
                end else if (mc == pulse_at + TIMEOUT - 1) begin
                    tmo_ev = 1; busy = 0; free_at = mc + 2;
                end
            end else if (e_oval && out_ready) begin
                e_oval = 0; busy = 0; free_at = mc + 2;
            end
            fire = !busy && nonempty && mc + 1 >= free_at;
            if (busy && mc == pulse_at) void'(mq.pop_front());
            e_fdv = fire;
            if (fire) begin
                busy = 1; pulse_at = mc + 1; e_fain = mq[0];
            end
            if (in_val && !full) mq.push_back(in_sample);
            e_ovf = (e_ovf && !clear_err) || (in_val && full);
            e_tmo = (e_tmo && !clear_err) || tmo_ev;
            e_lvl = mq.size();
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("filt_data_val", 32'(filt_data_val), 32'(e_fdv));
            chk("filt_audio_in", filt_audio_in, e_fain);
            chk("out_val", 32'(out_val), 32'(e_oval));
            chk("out_sample", out_sample, e_osamp);
            chk("fifo_level", 32'(fifo_level), 32'(e_lvl));
            chk("overflow_err", 32'(overflow_err), 32'(e_ovf));
            chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
        end
    end

    // Filter stand-in and cycle stepping
    int          cyc = 0, resp_at = 0, resp_lat = 1, npulse = 0;
    bit          pend = 0, resp_on = 0, resp_rand = 0, resp_fixed_en = 0;
    logic [31:0] resp_data, resp_fixed;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        in_val = 0; clear_err = 0; filt_audio_out_val = 0;
        if (pend && cyc == resp_at) begin
            filt_audio_out_val = 1; filt_audio_out = resp_data; pend = 0;
        end
        if (filt_data_val) begin
            npulse++;
            if (resp_on) begin
                pend      = 1;
                resp_at   = cyc + (resp_rand ? ($urandom_range(0, 9) == 0 ?
                            int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1)) : int'($urandom_range(1, 20))) : resp_lat);
                resp_data = resp_fixed_en ? resp_fixed : ~filt_audio_in;
            end
        end
    endtask

    task automatic do_reset();
        step(); rst = 1; step(); step(); rst = 0;
        pend = 0; npulse = 0; resp_rand = 0; resp_fixed_en = 0;
    endtask

    task automatic wait_pulse(input int n, output int pc);
        pc = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (filt_data_val) begin pc = cyc; break; end
        end
    endtask

    task automatic push(input logic [31:0] v);
        step(); in_val = 1; in_sample = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, pc;
        logic [31:0] got[$];
        rst = 1; in_val = 0; in_sample = '0; filt_audio_out_val = 0; filt_audio_out = '0;
        out_ready = 0; clear_err = 0;
        do_reset();
        chk("reset_out_val", 32'(out_val), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);

        // Single sample, response 15 cycles after the pulse
        resp_on = 1; resp_lat = 15; resp_fixed_en = 1; resp_fixed = 32'h0800_0000; out_ready = 1;
        push(32'h1000_0000); t0 = cyc;
        wait_pulse(10, pc);
        chk("pulse_latency", 32'(pc - t0), 32'd2);
        chk("issue_word", filt_audio_in, 32'h1000_0000);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) begin
                chk("single_pulse", 32'(filt_data_val), 32'd0);
                chk("level_after_pop", 32'(fifo_level), 32'd0);
            end
            if (k == 15) begin
                chk("no_early_out", 32'(out_val), 32'd0);
                chk("issue_word_held", filt_audio_in, 32'h1000_0000);
            end
            if (k == 16) begin
                chk("out_val_rise", 32'(out_val), 32'd1);
                chk("out_sample", out_sample, 32'h0800_0000);
            end
        end
        step();
        chk("out_accepted", 32'(out_val), 32'd0);

        // Timeout, then next queued sample issues, then clear_err
        do_reset(); resp_on = 0; out_ready = 1;
        push(32'hAAAA_0001); push(32'hBBBB_0002);
        wait_pulse(10, pc);
        while (cyc < pc + TIMEOUT - 1) step();
        chk("timeout_not_yet", 32'(timeout_err), 32'd0);
        step();
        chk("timeout_at_T", 32'(timeout_err), 32'd1);
        step();
        chk("next_issue_pulse", 32'(filt_data_val), 32'd1);
        chk("next_issue_word", filt_audio_in, 32'hBBBB_0002);
        step(); clear_err = 1;
        step();
        chk("clear_err", 32'(timeout_err), 32'd0);

        // Response coincident with timeout expiry wins
        do_reset(); resp_on = 1; resp_lat = TIMEOUT - 1; out_ready = 1;
        push(32'h8000_0123);
        wait_pulse(10, pc);
        while (cyc < pc + TIMEOUT) step();
        chk("coincident_out_val", 32'(out_val), 32'd1);
        chk("coincident_sample", out_sample, 32'h7FFF_FEDC);
        chk("coincident_no_tmo", 32'(timeout_err), 32'd0);

        // Stray response while idle
        step(); step(); filt_audio_out_val = 1; filt_audio_out = 32'hDEAD_BEEF;
        step();
        chk("stray_ignored", 32'(out_val), 32'd0);

        // Burst with backpressure: 10 pushes, the 10th finds the FIFO full
        do_reset(); resp_on = 1; resp_lat = 3; out_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) chk("no_ovf_before_full", 32'(overflow_err), 32'd0);
            in_val = 1; in_sample = 32'(k);
        end
        step();
        chk("overflow_err", 32'(overflow_err), 32'd1);
        chk("level_full", 32'(fifo_level), 32'd8);
        t0 = npulse;
        repeat (50) step();
        chk("bp_out_val", 32'(out_val), 32'd1);
        chk("bp_out_sample", out_sample, 32'hFFFF_FFFE);
        chk("bp_no_issue", 32'(npulse), 32'(t0));
        out_ready = 1;
        for (int i = 0; i < 600; i++) begin
            if (out_val) got.push_back(out_sample);
            if (got.size() == 9) break;
            step();
        end
        chk("burst_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < got.size(); i++) chk("burst_order", got[i], ~32'(i + 1));
        chk("burst_pulses", 32'(npulse), 32'd9);

        // Reset mid-WAIT with samples queued; late response ignored
        do_reset(); resp_on = 0; out_ready = 1;
        for (int k = 0; k < 4; k++) push(32'h0100_0000 + 32'(k));
        wait_pulse(10, pc);
        step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_fain", filt_audio_in, 32'd0);
        chk("rst_flags", 32'({filt_data_val, out_val, overflow_err, timeout_err}), 32'd0);
        filt_audio_out_val = 1; filt_audio_out = 32'h1234_5678;
        step();
        chk("late_resp_ignored", 32'(out_val), 32'd0);

        // Randomized traffic
        do_reset(); resp_on = 1; resp_rand = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            in_val    = $urandom_range(0, 9) < 4;
            in_sample = $urandom;
            out_ready = $urandom_range(0, 9) < 7;
            clear_err = $urandom_range(0, 49) == 0;
            if (!filt_audio_out_val && $urandom_range(0, 39) == 0) begin
                filt_audio_out_val = 1; filt_audio_out = $urandom;
            end
            rst = $urandom_range(0, 499) == 0;
        end
        step(); rst = 0;
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/iir_sample_sequencer.md
Name: iir_sample_sequencer

Overview:
- Initiator side of the filter's sample handshake. Accepts audio samples from the codec/ADC path and buffers them in a small FIFO.
- Issues samples one at a time to the IIR filter core as a single-cycle data-valid pulse plus a held sample word. It waits for the filter's output-valid pulse, then presents the filtered result downstream on a valid/ready port.
- Sits between the audio input deserialiser and the 6th-order IIR filter in the pitch-shifter datapath.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
TIMEOUT, 64, cycles to wait for the filter response before abandoning the sample; minimum 20

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_sample  input  32  signed 2's-complement sample from upstream
in_val  input  1  one-cycle strobe; in_sample is valid this cycle
filt_audio_in  output  32  sample to the filter; held stable from issue until response or timeout
filt_data_val  output  1  one-cycle start pulse to the filter
filt_audio_out  input  32  filter result
filt_audio_out_val  input  1  one-cycle filter result strobe
out_sample  output  32  filtered sample to downstream
out_val  output  1  out_sample valid; held until accepted
out_ready  input  1  downstream accepts when out_val && out_ready
fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy
overflow_err  output  1  sticky: a sample was dropped because the FIFO was full
timeout_err  output  1  sticky: the filter did not respond within TIMEOUT cycles
clear_err  input  1  clears both sticky flags next edge

Behaviour:
- Reset: all outputs 0; FIFO emptied (pointers 0); state IDLE; timeout counter 0. Reset overrides all other activity mid-operation; in-flight and buffered samples are discarded.
- FIFO push:
  - in_val with occupancy < DEPTH writes in_sample at the tail.
  - in_val with occupancy == DEPTH drops the sample and sets overflow_err.
  - Fullness is judged on the pre-edge occupancy, so a push when full is dropped even if a pop happens the same cycle.
  - A simultaneous push and pop when not full leaves the occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty and out_val == 0, go to ISSUE. Otherwise stay.
  - ISSUE: one cycle. Register filt_audio_in <= FIFO head and pop the head. filt_data_val is high for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: filt_audio_in held. The counter increments each cycle.
    - On filt_audio_out_val: out_sample <= filt_audio_out, out_val <= 1, go to OUT.
    - Else if the counter reaches TIMEOUT-1: set timeout_err, drop the sample, go to IDLE.
    - If filt_audio_out_val arrives on the same cycle as the timeout expiry, the response wins; no error is raised.
  - OUT: out_val held with out_sample stable. On out_ready, out_val <= 0 and go to IDLE. No new issue occurs while out_val is high (backpressure).
- filt_audio_out_val outside WAIT is ignored; state and outputs are unchanged.
- clear_err: both sticky flags go to 0 on the next edge. If a new error event occurs on the same cycle as clear_err, set wins.
- Latency:
  - in_val in cycle T with the FIFO empty and FSM in IDLE gives filt_data_val in cycle T+2.
  - out_val rises the cycle after filt_audio_out_val.
  - Minimum spacing between consecutive filt_data_val pulses is response latency + 3 cycles with out_ready tied high.
- Widths: no arithmetic on sample data; 32-bit values pass through unmodified with sign preserved.

Test Plan:
- Single sample: reset, push in_sample=32'h1000_0000, filter model responds 15 cycles after the pulse with 32'h0800_0000, out_ready=1 -> filt_data_val high in exactly one cycle, two cycles after in_val; filt_audio_in=32'h1000_0000 held through the response; out_val one cycle after the response with out_sample=32'h0800_0000; fifo_level returns to 0.
- Burst: 8 back-to-back in_val (values 1..8), DEPTH=8, then a 9th value 9 -> fifo_level reaches 8 or 7 as pops occur. Expected behaviour:
  - If the 9th push finds the FIFO full, it is dropped and overflow_err=1.
  - Outputs appear in order with no reordering.
  - Exactly one filt_data_val per accepted sample.
- Backpressure: hold out_ready=0 for 50 cycles after the first result -> out_val stays 1 with out_sample stable; no second filt_data_val until the cycle after out_ready=1 acceptance.
- Timeout: filter model never responds -> timeout_err=1 exactly TIMEOUT cycles after the pulse; FSM returns to IDLE and the next queued sample is issued; clear_err returns timeout_err to 0.
- Stray/edge: filt_audio_out_val pulsed in IDLE -> no out_val. Response coincident with the timeout expiry cycle -> out_val=1 and timeout_err stays 0.
- Reset mid-WAIT with 3 samples queued -> next cycle all outputs 0 and fifo_level=0; a late filt_audio_out_val is ignored.
